// File: rtl/button_pkg.sv
// Shared state encoding and default timing table for the button debouncer/decoder family.
package button_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PRESS1 = 3'd1;
    localparam logic [2:0] ST_WAIT2  = 3'd2;
    localparam logic [2:0] ST_PRESS2 = 3'd3;
    localparam logic [2:0] ST_LONG   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        PRESS1 = ST_PRESS1,
        WAIT2  = ST_WAIT2,
        PRESS2 = ST_PRESS2,
        LONG   = ST_LONG
    } state_t;

    localparam int DEF_CNT_WIDTH   = 24;
    localparam int DEF_LONG_CNT    = 5000000;
    localparam int DEF_DBL_GAP_CNT = 2500000;
    localparam int DEF_REPEAT_CNT  = 1000000;

endpackage

// File: rtl/event_timer.sv
// Cycle counter with synchronous clear, saturating increment and an equality tap
// against a limit chosen by the owner each cycle.
module event_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         clr,
    input  logic [W-1:0] limit,
    output logic         hit
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (cnt != '1)
            cnt <= cnt + 1'b1;
    end

    assign hit = (cnt == limit);

endmodule

// File: rtl/button_gesture_decoder.sv
// Classifies debounced press/release strobes into click, double click, long press
// and auto-repeat; all outputs registered.
module button_gesture_decoder
    import button_pkg::*;
#(
    parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
    parameter int LONG_CNT    = DEF_LONG_CNT,
    parameter int DBL_GAP_CNT = DEF_DBL_GAP_CNT,
    parameter int REPEAT_CNT  = DEF_REPEAT_CNT
) (
    input  logic clk,
    input  logic arst_n,
    input  logic en_i,
    input  logic sw_down_i,
    input  logic sw_up_i,
    output logic click_o,
    output logic dbl_click_o,
    output logic long_press_o,
    output logic repeat_o,
    output logic held_o
);

    // A timeout of X fires while the counter reads X-1.
    localparam logic [CNT_WIDTH-1:0] LONG_LIM = CNT_WIDTH'(LONG_CNT - 1);
    localparam logic [CNT_WIDTH-1:0] GAP_LIM  = CNT_WIDTH'(DBL_GAP_CNT - 1);
    localparam logic [CNT_WIDTH-1:0] REP_LIM  = CNT_WIDTH'(REPEAT_CNT - 1);

    state_t               state, nxt;
    logic                 clr, hit;
    logic [CNT_WIDTH-1:0] limit;
    logic                 ev_down, ev_up;
    logic                 p_click, p_dbl, p_long, p_rep, rep_clr;

    // Simultaneous down and up cancel each other out.
    assign ev_down = sw_down_i & ~sw_up_i;
    assign ev_up   = sw_up_i & ~sw_down_i;

    always_comb begin
        case (state)
            PRESS1:  limit = LONG_LIM;
            WAIT2:   limit = GAP_LIM;
            LONG:    limit = REP_LIM;
            default: limit = '0;
        endcase
    end

    event_timer #(.W(CNT_WIDTH)) u_timer (
        .clk    (clk),
        .arst_n (arst_n),
        .clr    (clr),
        .limit  (limit),
        .hit    (hit)
    );

    // Events are tested before timeouts so an edge always wins a same-cycle tie.
    always_comb begin
        nxt     = state;
        p_click = 1'b0;
        p_dbl   = 1'b0;
        p_long  = 1'b0;
        p_rep   = 1'b0;
        rep_clr = 1'b0;
        case (state)
            IDLE:   if (ev_down) nxt = PRESS1;
            PRESS1: begin
                if (ev_up)    nxt = WAIT2;
                else if (hit) begin nxt = LONG; p_long = 1'b1; end
            end
            WAIT2: begin
                if (ev_down)  begin nxt = PRESS2; p_dbl = 1'b1; end
                else if (hit) begin nxt = IDLE; p_click = 1'b1; end
            end
            PRESS2: if (ev_up) nxt = IDLE;
            LONG: begin
                if (ev_up)    nxt = IDLE;
                else if (hit) begin p_rep = 1'b1; rep_clr = 1'b1; end
            end
            default: nxt = IDLE;
        endcase
        if (!en_i) begin
            nxt     = IDLE;
            p_click = 1'b0;
            p_dbl   = 1'b0;
            p_long  = 1'b0;
            p_rep   = 1'b0;
        end
        clr = rep_clr | (nxt != state) | ~en_i;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state        <= IDLE;
            click_o      <= 1'b0;
            dbl_click_o  <= 1'b0;
            long_press_o <= 1'b0;
            repeat_o     <= 1'b0;
            held_o       <= 1'b0;
        end else begin
            state        <= nxt;
            click_o      <= p_click;
            dbl_click_o  <= p_dbl;
            long_press_o <= p_long;
            repeat_o     <= p_rep;
            held_o       <= (nxt == PRESS1) || (nxt == PRESS2) || (nxt == LONG);
        end
    end

endmodule

// File: tb/tb_button_gesture_decoder.sv
// Randomized + directed check of button_gesture_decoder against a timestamp-based gesture model.
module tb_button_gesture_decoder;

    localparam int CW  = 8;
    localparam int LNG = 20;
    localparam int GAP = 10;
    localparam int REP = 5;

    logic clk = 1'b0, arst_n = 1'b0, en_i = 1'b1, sw_down_i = 1'b0, sw_up_i = 1'b0;
    logic click_o, dbl_click_o, long_press_o, repeat_o, held_o;

    int total = 0, bad = 0;
    int n_click = 0;

    button_gesture_decoder #(.CNT_WIDTH(CW), .LONG_CNT(LNG), .DBL_GAP_CNT(GAP), .REPEAT_CNT(REP)) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .en_i         (en_i),
        .sw_down_i    (sw_down_i),
        .sw_up_i      (sw_up_i),
        .click_o      (click_o),
        .dbl_click_o  (dbl_click_o),
        .long_press_o (long_press_o),
        .repeat_o     (repeat_o),
        .held_o       (held_o)
    );

    always #5 clk = ~clk;

    // Gesture model: phase plus the edge index at which the phase was entered;
    // timeouts are elapsed-edge arithmetic. Phases: 0 idle,1 first press,2 gap,3 second press,4 long.
    typedef struct {
        int ph;
        int t0;
        bit click, dbl, lng, rep;
    } mdl_t;

    mdl_t m;
    int   n;

    function automatic mdl_t step(mdl_t cur, int e, bit en, bit d, bit u);
        mdl_t r;
        int   el;
        bit   dn, up;
        r = cur;
        r.click = 0; r.dbl = 0; r.lng = 0; r.rep = 0;
        dn = d && !u;
        up = u && !d;
        el = e - cur.t0;
        if (!en) begin
            r.ph = 0; r.t0 = e;
            return r;
        end
        case (cur.ph)
            0: if (dn) begin r.ph = 1; r.t0 = e; end
            1: if (up) begin r.ph = 2; r.t0 = e; end
               else if (el == LNG) begin r.ph = 4; r.t0 = e; r.lng = 1; end
            2: if (dn) begin r.ph = 3; r.t0 = e; r.dbl = 1; end
               else if (el == GAP) begin r.ph = 0; r.t0 = e; r.click = 1; end
            3: if (up) begin r.ph = 0; r.t0 = e; end
            default: if (up) begin r.ph = 0; r.t0 = e; end
                     else if (el > 0 && el % REP == 0) r.rep = 1;
        endcase
        return r;
    endfunction

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            n <= 0;
            m <= '{0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        end else begin
            n <= n + 1;
            m <= step(m, n + 1, en_i, sw_down_i, sw_up_i);
        end
    end

    always @(negedge clk) if (arst_n && click_o) n_click <= n_click + 1;

    task automatic chk(string name, logic act, logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t act=%0b exp=%0b", name, $time, act, exp);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (arst_n) begin
                chk("m_click", click_o, m.click);
                chk("m_dbl", dbl_click_o, m.dbl);
                chk("m_long", long_press_o, m.lng);
                chk("m_rep", repeat_o, m.rep);
                chk("m_held", held_o, (m.ph == 1 || m.ph == 3 || m.ph == 4));
                chk("onehot", ((click_o + dbl_click_o + long_press_o + repeat_o) <= 1), 1'b1);
            end
        end
    endtask

    task automatic drive(bit d, bit u);
        sw_down_i = d;
        sw_up_i   = u;
        @(negedge clk);
        sw_down_i = 1'b0;
        sw_up_i   = 1'b0;
    endtask

    task automatic idle(int k);
        repeat (k) @(negedge clk);
    endtask

    initial begin
        int c0;
        fork
            compare_loop();
        join_none

        // reset state
        idle(2);
        chk("rst_click", click_o, 1'b0);
        chk("rst_dbl", dbl_click_o, 1'b0);
        chk("rst_long", long_press_o, 1'b0);
        chk("rst_rep", repeat_o, 1'b0);
        chk("rst_held", held_o, 1'b0);
        arst_n = 1'b1;
        idle(3);

        // single click: up 5 cycles after down, click 10 cycles after up
        drive(1, 0);
        chk("t1_held", held_o, 1'b1);
        idle(4);
        drive(0, 1);
        idle(9);
        chk("t1_click_early", click_o, 1'b0);
        idle(1);
        chk("t1_click", click_o, 1'b1);
        idle(1);
        chk("t1_click_end", click_o, 1'b0);
        idle(3);

        // double click
        c0 = n_click;
        drive(1, 0);
        idle(2);
        drive(0, 1);
        idle(3);
        drive(1, 0);
        chk("t2_dbl", dbl_click_o, 1'b1);
        chk("t2_held", held_o, 1'b1);
        idle(2);
        drive(0, 1);
        chk("t2_idle", held_o, 1'b0);
        idle(12);
        chk("t2_noclick", (n_click == c0), 1'b1);

        // long press with repeats
        c0 = n_click;
        drive(1, 0);
        idle(19);
        chk("t3_long_early", long_press_o, 1'b0);
        idle(1);
        chk("t3_long", long_press_o, 1'b1);
        idle(5);
        chk("t3_rep25", repeat_o, 1'b1);
        idle(14);
        chk("t3_rep39", repeat_o, 1'b0);
        idle(1);
        chk("t3_rep40", repeat_o, 1'b1);
        drive(0, 1);
        idle(12);
        chk("t3_held", held_o, 1'b0);
        chk("t3_noclick", (n_click == c0), 1'b1);

        // collisions: up on long timeout, down on gap timeout
        c0 = n_click;
        drive(1, 0);
        idle(19);
        drive(0, 1);
        chk("t4_nolong", long_press_o, 1'b0);
        chk("t4_wait", held_o, 1'b0);
        idle(9);
        drive(1, 0);
        chk("t4_dbl", dbl_click_o, 1'b1);
        chk("t4_noclick", click_o, 1'b0);
        drive(0, 1);
        idle(12);
        chk("t4_clicks", (n_click == c0), 1'b1);

        // async reset while in LONG
        drive(1, 0);
        idle(25);
        #2 arst_n = 1'b0;
        #1;
        chk("t5_held", held_o, 1'b0);
        chk("t5_rep", repeat_o, 1'b0);
        chk("t5_long", long_press_o, 1'b0);
        @(negedge clk);
        arst_n = 1'b1;
        c0 = n_click;
        drive(0, 1);
        idle(12);
        chk("t5_quiet", (n_click == c0) && !held_o, 1'b1);

        // enable dropped during the gap
        c0 = n_click;
        drive(1, 0);
        idle(2);
        drive(0, 1);
        idle(3);
        en_i = 1'b0;
        @(negedge clk);
        en_i = 1'b1;
        idle(12);
        chk("t6_noclick", (n_click == c0), 1'b1);

        // down and up together from idle
        drive(1, 1);
        idle(2);
        chk("t6_both", held_o, 1'b0);
        idle(12);
        chk("t6_both_click", (n_click == c0), 1'b1);

        // randomized
        repeat (250) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: drive(1, 0);
                4, 5, 6, 7: drive(0, 1);
                8: begin en_i = 1'b0; drive(0, 0); en_i = 1'b1; end
                default: drive(0, 0);
            endcase
            idle($urandom_range(0, 30));
        end

        idle(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
